dh_exchange_ctrl: RTL and testbench
===================================

DH_EXCHANGE_CTRL -- requirements
Module: dh_exchange_ctrl

Interface
REQ-001 Parameter W, default 32, operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles to wait for engine done per operation.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 ST  in  1  start request; a rising edge seen while IDLE launches one exchange.
REQ-006 G, P, X, Y  in  W each  generator, modulus, private key A, private key B; latched on launch.
REQ-007 eng_start  out  1  one-cycle pulse; engine begins eng_base^eng_exp mod eng_mod.
REQ-008 eng_base, eng_exp, eng_mod  out  W each  engine operands; held stable from the eng_start cycle until eng_done.
REQ-009 eng_done  in  1  engine completion pulse; eng_result is valid in the same cycle.
REQ-010 eng_result  in  W  engine result.
REQ-011 pub_a, pub_b, key  out  W each  public values and agreed shared key.
REQ-012 valid  out  1  one-cycle pulse when pub_a, pub_b and key are final.
REQ-013 match  out  1  both parties' keys equal; qualified by valid.
REQ-014 busy  out  1  high from launch until valid or error.
REQ-015 error  out  1  sticky fault flag, cleared by the next launch or by RST.

Function
REQ-016 States are IDLE, ISSUE, WAIT, CHECK, DONE and ERR; a 2-bit op index selects the current operation.
REQ-017 Op sequence: op0 G^X -> pub_a; op1 G^Y -> pub_b; op2 pub_b^X -> ka; op3 pub_a^Y -> kb.
REQ-018 IDLE->ISSUE on ST rising edge (ST high, previous-cycle ST low); inputs latched that cycle; op=0; error cleared.
REQ-019 IDLE->ERR instead when latched P<2; eng_start is never asserted in that case.
REQ-020 ISSUE asserts eng_start for exactly one cycle, then moves to WAIT; the timeout counter is cleared.
REQ-021 WAIT on eng_done stores eng_result; if op<3 then op++ and ->ISSUE, else ->CHECK.
REQ-022 WAIT without eng_done increments the timeout counter; counter = TIMEOUT-1 -> ERR.
REQ-023 eng_done outside WAIT is ignored; it changes no state or register.
REQ-024 CHECK: key<=ka; match<=(ka==kb); ->DONE.
REQ-025 DONE: valid=1 for one cycle, busy=0, ->IDLE; outputs hold until the next launch.
REQ-026 ERR: busy=0, error=1, ->IDLE; pub_a/pub_b/key keep prior values.
REQ-027 ST held high across completion does not relaunch; a new rising edge is required.
REQ-028 G, P, X and Y changing after launch do not affect the running exchange.
REQ-029 Minimum latency, launch to valid: 4*(2+engine latency)+2 cycles.

Reset
REQ-030 While RST is high: state=IDLE, op=0, counter=0, ST edge history=1 (no launch on release with ST high), all outputs 0.
REQ-031 RST mid-operation aborts immediately; eng_start is 0 in the following cycle and late eng_done is ignored.

Structure
REQ-032 Package dh_pkg holds the state enum, op index encodings, default W and default TIMEOUT.
REQ-033 One sub-module, dh_timeout_cnt: clear/enable counter with a terminal-count flag at TIMEOUT-1.
REQ-034 Operand muxing, the ST edge detector and the FSM live in dh_exchange_ctrl.

Verification
REQ-035 Bench uses a behavioural engine model with 3-cycle latency. Case G=17, P=5, X=6, Y=8, ST 0->1 -> pub_a=4, pub_b=1, key=1, match=1, valid after 22 cycles.
REQ-036 Case G=5, P=23, X=6, Y=15 -> pub_a=8, pub_b=19, key=2, match=1; exactly four eng_start pulses are issued.
REQ-037 Case P=1 with ST rising edge -> error=1 two cycles later, no eng_start, valid never asserts.
REQ-038 Engine model never asserts done with TIMEOUT=16 -> error after 16 WAIT cycles; busy=0; the next ST edge relaunches and clears error.
REQ-039 Case RST pulsed during op2 -> all outputs 0 and state IDLE; a stray eng_done afterwards is ignored; ST held high after reset does not launch.
REQ-040 Model corrupts op3 result to ka+1 -> valid=1, match=0, key=ka.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared constants for the Diffie-Hellman exchange controller.
// FSM state codes, operation indices and parameter defaults.
package dh_pkg;

    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 1024;

    typedef logic [2:0] state_t;
    typedef logic [1:0] op_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ISSUE = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_CHECK = 3'd3;
    localparam state_t S_DONE  = 3'd4;
    localparam state_t S_ERR   = 3'd5;

    localparam op_t OP_PUB_A = 2'd0;
    localparam op_t OP_PUB_B = 2'd1;
    localparam op_t OP_KEY_A = 2'd2;
    localparam op_t OP_KEY_B = 2'd3;

endpackage

// File: rtl/dh_exchange_ctrl_if.sv
// Modular-exponentiation engine handshake.
// master = controller side, slave = engine side.
interface dh_exchange_ctrl_if
    import dh_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         eng_start;
    logic [W-1:0] eng_base;
    logic [W-1:0] eng_exp;
    logic [W-1:0] eng_mod;
    logic         eng_done;
    logic [W-1:0] eng_result;

    modport master (
        output eng_start, eng_base, eng_exp, eng_mod,
        input  eng_done, eng_result
    );

    modport slave (
        input  eng_start, eng_base, eng_exp, eng_mod,
        output eng_done, eng_result
    );
endinterface

// File: rtl/dh_timeout_cnt.sv
// Clear/enable wait counter; tc flags the last permitted wait cycle.
// Saturates at TIMEOUT-1 so tc stays asserted until cleared.
module dh_timeout_cnt
    import dh_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dh_exchange_ctrl.sv
// Sequences four modexp operations to derive both public values
// and both parties' shared keys, then reports key agreement.
module dh_exchange_ctrl
    import dh_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ST,
    input  logic [W-1:0]       G,
    input  logic [W-1:0]       P,
    input  logic [W-1:0]       X,
    input  logic [W-1:0]       Y,
    dh_exchange_ctrl_if.master eng,
    output logic [W-1:0]       pub_a,
    output logic [W-1:0]       pub_b,
    output logic [W-1:0]       key,
    output logic               valid,
    output logic               match,
    output logic               busy,
    output logic               error
);
    state_t       state;
    op_t          op;
    logic         st_q;
    logic         launch;
    logic         in_wait;
    logic         tc;
    logic [W-1:0] g_r, p_r, x_r, y_r;
    logic [W-1:0] pa_r, pb_r, ka_r, kb_r;

    assign launch  = (state == S_IDLE) && ST && !st_q;
    assign in_wait = (state == S_WAIT);

    dh_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk (CLK),
        .rst (RST),
        .clr (!in_wait),
        .en  (in_wait && !eng.eng_done),
        .tc  (tc)
    );

    // Operands come from latched registers only, so they stay stable
    // for the whole ISSUE/WAIT window of each operation.
    always_comb begin
        eng.eng_base = g_r;
        eng.eng_exp  = x_r;
        unique case (op)
            OP_PUB_A: ;
            OP_PUB_B: eng.eng_exp = y_r;
            OP_KEY_A: eng.eng_base = pb_r;
            OP_KEY_B: begin
                eng.eng_base = pa_r;
                eng.eng_exp  = y_r;
            end
        endcase
    end

    assign eng.eng_mod   = p_r;
    assign eng.eng_start = (state == S_ISSUE);
    assign valid         = (state == S_DONE);
    assign busy          = (state == S_ISSUE) ||
                           (state == S_WAIT)  ||
                           (state == S_CHECK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            op    <= OP_PUB_A;
            st_q  <= 1'b1;
            g_r   <= '0;
            p_r   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            pa_r  <= '0;
            pb_r  <= '0;
            ka_r  <= '0;
            kb_r  <= '0;
            pub_a <= '0;
            pub_b <= '0;
            key   <= '0;
            match <= 1'b0;
            error <= 1'b0;
        end else begin
            st_q <= ST;
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        g_r   <= G;
                        p_r   <= P;
                        x_r   <= X;
                        y_r   <= Y;
                        op    <= OP_PUB_A;
                        error <= 1'b0;
                        state <= (P < W'(2)) ? S_ERR : S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (eng.eng_done) begin
                        unique case (op)
                            OP_PUB_A: pa_r <= eng.eng_result;
                            OP_PUB_B: pb_r <= eng.eng_result;
                            OP_KEY_A: ka_r <= eng.eng_result;
                            OP_KEY_B: kb_r <= eng.eng_result;
                        endcase
                        if (op == OP_KEY_B) begin
                            state <= S_CHECK;
                        end else begin
                            op    <= op + 2'd1;
                            state <= S_ISSUE;
                        end
                    end else if (tc) begin
                        state <= S_ERR;
                    end
                end
                S_CHECK: begin
                    pub_a <= pa_r;
                    pub_b <= pb_r;
                    key   <= ka_r;
                    match <= (ka_r == kb_r);
                    state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                S_ERR: begin
                    error <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// Randomized bench for dh_exchange_ctrl with a behavioural modexp
// engine and an exchange-level reference model.
module tb_dh_exchange_ctrl;
    import dh_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 16;
    localparam int ENG_LAT = 3;

    logic         clk = 1'b0;
    logic         rst, st;
    logic [W-1:0] g, p, x, y;
    logic [W-1:0] pub_a, pub_b, key;
    logic         valid, match, busy, error;

    dh_exchange_ctrl_if #(.W(W)) eng_if ();

    dh_exchange_ctrl #(
        .W       (W),
        .TIMEOUT (TMO)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .ST    (st),
        .G     (g),
        .P     (p),
        .X     (x),
        .Y     (y),
        .eng   (eng_if),
        .pub_a (pub_a),
        .pub_b (pub_b),
        .key   (key),
        .valid (valid),
        .match (match),
        .busy  (busy),
        .error (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fails = 0;

    bit           chk_en = 0, hang = 0, corrupt = 0;
    int           lc = -1000, exp_valid = -1000, start_base = 0;
    logic [W-1:0] e_pa, e_pb, e_key, e_mod;
    logic         e_match;
    logic [W-1:0] op_b [4];
    logic [W-1:0] op_e [4];

    int           start_cnt = 0, valid_cnt = 0, last_valid = -1;
    int           done_at = -1;
    bit           pend = 0;
    logic [W-1:0] res, r2;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b,
                                            input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        longint unsigned r, bb, mm;
        if (m == '0) return '0;
        mm = 64'(m);
        r  = 64'd1 % mm;
        bb = 64'(b) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return W'(r);
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Engine model plus per-cycle comparison against the exchange model
    always @(negedge clk) begin
        int d, k;
        eng_if.eng_done = 1'b0;
        if (pend && cyc == done_at) begin
            eng_if.eng_done   = 1'b1;
            eng_if.eng_result = res;
            pend = 0;
        end
        d = cyc - lc;
        if (eng_if.eng_start) begin
            k = start_cnt - start_base;
            if (chk_en && k < 4) begin
                check("op_base", 64'(eng_if.eng_base), 64'(op_b[k]));
                check("op_exp", 64'(eng_if.eng_exp), 64'(op_e[k]));
                check("op_mod", 64'(eng_if.eng_mod), 64'(e_mod));
            end
            if (!hang) begin
                res = modexp(eng_if.eng_base, eng_if.eng_exp, eng_if.eng_mod);
                if (k == 2) r2 = res;
                if (k == 3 && corrupt) res = r2 + W'(1);
                pend    = 1;
                done_at = cyc + ENG_LAT + 1;
            end
            start_cnt++;
        end
        if (valid) begin
            valid_cnt++;
            last_valid = cyc;
        end
        if (chk_en) begin
            check("eng_start", 64'(eng_if.eng_start),
                  64'(d >= 1 && d <= 16 && (d - 1) % 5 == 0));
            check("valid", 64'(valid), 64'(cyc == exp_valid));
            check("busy", 64'(busy), 64'(d >= 1 && cyc < exp_valid));
            if (d >= 1) check("error", 64'(error), 64'd0);
            if (valid) begin
                check("pub_a", 64'(pub_a), 64'(e_pa));
                check("pub_b", 64'(pub_b), 64'(e_pb));
                check("key", 64'(key), 64'(e_key));
                check("match", 64'(match), 64'(e_match));
            end
        end
    end

    task automatic launch(input logic [W-1:0] gi, input logic [W-1:0] pi,
                          input logic [W-1:0] xi, input logic [W-1:0] yi,
                          input bit corr, input bit model);
        logic [W-1:0] ka, kb;
        st = 1'b1;
        g  = gi;
        p  = pi;
        x  = xi;
        y  = yi;
        e_pa    = modexp(gi, xi, pi);
        e_pb    = modexp(gi, yi, pi);
        ka      = modexp(e_pb, xi, pi);
        kb      = corr ? ka + W'(1) : modexp(e_pa, yi, pi);
        e_key   = ka;
        e_match = (ka == kb);
        e_mod   = pi;
        op_b    = '{gi, gi, e_pb, e_pa};
        op_e    = '{xi, yi, xi, yi};
        corrupt    = corr;
        lc         = cyc;
        exp_valid  = cyc + 4 * (2 + ENG_LAT) + 2;
        start_base = start_cnt;
        chk_en     = model;
    endtask

    task automatic run_exchange(input logic [W-1:0] gi, input logic [W-1:0] pi,
                                input logic [W-1:0] xi, input logic [W-1:0] yi,
                                input bit corr, input int hold,
                                input bit scramble);
        int n;
        n = (hold > 24) ? hold : 24;
        launch(gi, pi, xi, yi, corr, 1'b1);
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (scramble) begin
                g = $urandom;
                p = $urandom;
                x = $urandom;
                y = $urandom;
            end
            if (i >= hold) st = 1'b0;
        end
        st = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [W-1:0] pa0, rg, rp, rx, ry;
        int s0, v0;
        rst = 1'b1;
        st  = 1'b1;
        g   = '0;
        p   = '0;
        x   = '0;
        y   = '0;
        tick(3);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_start", 64'(eng_if.eng_start), 64'd0);
        check("rst_pub_a", 64'(pub_a), 64'd0);
        check("rst_pub_b", 64'(pub_b), 64'd0);
        check("rst_key", 64'(key), 64'd0);
        check("rst_match", 64'(match), 64'd0);
        check("rst_base", 64'(eng_if.eng_base), 64'd0);
        rst = 1'b0;
        tick(6);
        check("rel_busy", 64'(busy), 64'd0);
        check("rel_nolaunch", 64'(start_cnt), 64'd0);
        st = 1'b0;
        tick(2);

        run_exchange(17, 5, 6, 8, 1'b0, 1, 1'b0);
        check("c1_pub_a", 64'(pub_a), 64'd4);
        check("c1_pub_b", 64'(pub_b), 64'd1);
        check("c1_key", 64'(key), 64'd1);
        check("c1_match", 64'(match), 64'd1);
        check("c1_latency", 64'(last_valid - lc), 64'd22);

        run_exchange(5, 23, 6, 15, 1'b0, 1, 1'b1);
        check("c2_pub_a", 64'(pub_a), 64'd8);
        check("c2_pub_b", 64'(pub_b), 64'd19);
        check("c2_key", 64'(key), 64'd2);
        check("c2_match", 64'(match), 64'd1);
        check("c2_starts", 64'(start_cnt - start_base), 64'd4);

        for (int t = 0; t < 14; t++) begin
            rp = (t < 4) ? W'($urandom_range(2, 40)) :
                           ($urandom % 32'hFFFF_FFF0) + 32'd2;
            rg = $urandom;
            rx = $urandom;
            ry = $urandom;
            run_exchange(rg, rp, rx, ry, 1'b0, $urandom_range(1, 30), 1'b1);
        end

        run_exchange(5, 23, 6, 15, 1'b1, 1, 1'b0);
        check("cor_valid", 64'(last_valid - lc), 64'd22);
        check("cor_match", 64'(match), 64'd0);
        check("cor_key", 64'(key), 64'd2);
        run_exchange($urandom, 32'd1_000_003, $urandom, $urandom, 1'b1, 3, 1'b1);

        for (int t = 0; t < 2; t++) begin
            pa0 = pub_a;
            s0  = start_cnt;
            v0  = valid_cnt;
            launch(7, W'(1 - t), 3, 4, 1'b0, 1'b0);
            tick(1);
            check("perr_early", 64'(error), 64'd0);
            tick(1);
            check("perr_error", 64'(error), 64'd1);
            check("perr_busy", 64'(busy), 64'd0);
            st = 1'b0;
            tick(8);
            check("perr_nostart", 64'(start_cnt), 64'(s0));
            check("perr_novalid", 64'(valid_cnt), 64'(v0));
            check("perr_hold", 64'(pub_a), 64'(pa0));
            check("perr_sticky", 64'(error), 64'd1);
        end

        hang = 1;
        pa0  = pub_a;
        launch(5, 23, 6, 15, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            st = 1'b0;
            if (error) break;
        end
        check("tmo_latency", 64'(cyc - lc), 64'd19);
        check("tmo_error", 64'(error), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_hold", 64'(pub_a), 64'(pa0));
        check("tmo_starts", 64'(start_cnt - start_base), 64'd1);
        hang = 0;
        tick(2);
        run_exchange(5, 23, 6, 15, 1'b0, 1, 1'b0);
        check("tmo_relaunch_err", 64'(error), 64'd0);
        check("tmo_relaunch_key", 64'(key), 64'd2);

        launch($urandom, 32'd65_537, $urandom, $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 40 && (start_cnt - start_base) < 3; i++) tick(1);
        check("rop2_reached", 64'(start_cnt - start_base), 64'd3);
        chk_en = 0;
        tick(1);
        rst = 1'b1;
        tick(1);
        check("rop2_valid", 64'(valid), 64'd0);
        check("rop2_busy", 64'(busy), 64'd0);
        check("rop2_error", 64'(error), 64'd0);
        check("rop2_start", 64'(eng_if.eng_start), 64'd0);
        check("rop2_pub_a", 64'(pub_a), 64'd0);
        check("rop2_pub_b", 64'(pub_b), 64'd0);
        check("rop2_key", 64'(key), 64'd0);
        check("rop2_match", 64'(match), 64'd0);
        rst = 1'b0;
        s0  = start_cnt;
        v0  = valid_cnt;
        tick(10);
        check("rop2_nostart", 64'(start_cnt), 64'(s0));
        check("rop2_novalid", 64'(valid_cnt), 64'(v0));
        check("rop2_idle", 64'(busy), 64'd0);
        check("rop2_stray", 64'(pub_a), 64'd0);
        st = 1'b0;
        tick(2);
        run_exchange(17, 5, 6, 8, 1'b0, 2, 1'b1);
        check("final_key", 64'(key), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
